// File: rtl/inst_sram_responder.sv
// inst_sram_responder: responder end of the CPU's SRAM-style instruction port.
// A word-organised memory with byte-lane writes and registered (synchronous) read data.
// An optional fixed wait-state count holds sram_busy high for WAIT_CYCLES cycles after
// each accepted access. The hazard unit folds sram_busy into the fetch stall.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high
//   sram_en     access request
//   sram_wen    byte write enables; all-zero means read
//   sram_addr   physical byte address (after kseg0/kseg1 translation)
//   sram_wdata  write data
//   sram_rdata  registered read data; changes only when a read completes
//   sram_busy   high while an access is in its wait states
//   addr_err    one-cycle pulse after an access outside the window completes
//   rd_count    completed in-window reads, wraps

module inst_sram_responder #(
    parameter int unsigned ADDR_W      = 14,
    parameter logic [31:0] BASE_ADDR   = 32'h1fc0_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic        sram_busy,
    output logic        addr_err,
    output logic [31:0] rd_count
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic {StIdle, StWait} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   lat_idx_q, lat_idx_d;
    logic [3:0]          lat_wen_q, lat_wen_d;
    logic [31:0]         lat_wdata_q, lat_wdata_d;
    logic                lat_in_win_q, lat_in_win_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                addr_err_q, addr_err_d;
    logic [31:0]         rd_count_q, rd_count_d;

    logic [31:0]         mem_q [Depth];

    logic                req_in_win;
    logic [ADDR_W-1:0]   req_idx;
    logic                accept;

    // The access that completes at the coming edge, either straight from the port
    // (no wait states) or from the latched request (last wait cycle).
    logic                acc_fire;
    logic [ADDR_W-1:0]   acc_idx;
    logic [3:0]          acc_wen;
    logic [31:0]         acc_wdata;
    logic                acc_in_win;

    // Byte offset is deliberately ignored; misalignment is trapped by the fetch stage.
    logic                unused_addr_lsb;
    assign unused_addr_lsb = ^sram_addr[1:0];

    assign req_in_win = (sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign req_idx    = sram_addr[ADDR_W+1:2];
    assign sram_busy  = (state_q == StWait);
    assign accept     = sram_en && !sram_busy;

    always_comb begin
        if (WAIT_CYCLES == 0) begin
            acc_fire   = accept;
            acc_idx    = req_idx;
            acc_wen    = sram_wen;
            acc_wdata  = sram_wdata;
            acc_in_win = req_in_win;
        end else begin
            acc_fire   = (state_q == StWait) && (cnt_q == 4'd1);
            acc_idx    = lat_idx_q;
            acc_wen    = lat_wen_q;
            acc_wdata  = lat_wdata_q;
            acc_in_win = lat_in_win_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_idx_d    = lat_idx_q;
        lat_wen_d    = lat_wen_q;
        lat_wdata_d  = lat_wdata_q;
        lat_in_win_d = lat_in_win_q;
        rdata_d      = rdata_q;
        addr_err_d   = 1'b0;
        rd_count_d   = rd_count_q;

        unique case (state_q)
            StIdle: begin
                if ((WAIT_CYCLES != 0) && accept) begin
                    state_d      = StWait;
                    cnt_d        = 4'(WAIT_CYCLES);
                    lat_idx_d    = req_idx;
                    lat_wen_d    = sram_wen;
                    lat_wdata_d  = sram_wdata;
                    lat_in_win_d = req_in_win;
                end
            end
            StWait: begin
                // Requests arriving here are ignored; the initiator re-presents them.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (acc_fire) begin
            addr_err_d = !acc_in_win;
            // rdata only moves on a completed read; the fetch stage relies on it
            // persisting across idle, write and stall cycles.
            if (acc_wen == 4'b0000) begin
                if (acc_in_win) begin
                    rdata_d    = mem_q[acc_idx];
                    rd_count_d = rd_count_q + 32'd1;
                end else begin
                    rdata_d = 32'h0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            lat_idx_q    <= '0;
            lat_wen_q    <= 4'd0;
            lat_wdata_q  <= 32'h0;
            lat_in_win_q <= 1'b0;
            rdata_q      <= 32'h0;
            addr_err_q   <= 1'b0;
            rd_count_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_idx_q    <= lat_idx_d;
            lat_wen_q    <= lat_wen_d;
            lat_wdata_q  <= lat_wdata_d;
            lat_in_win_q <= lat_in_win_d;
            rdata_q      <= rdata_d;
            addr_err_q   <= addr_err_d;
            rd_count_q   <= rd_count_d;
        end
    end

    // Memory is not reset; reset does block the write so a pending access is aborted.
    always_ff @(posedge clk) begin
        if (!reset && acc_fire && acc_in_win) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign sram_rdata = rdata_q;
    assign addr_err   = addr_err_q;
    assign rd_count   = rd_count_q;

endmodule

// File: doc/inst_sram_responder.md
Name: inst_sram_responder

Overview:
- Responder (slave) end of the CPU's SRAM-style instruction interface: en / wen / addr / wdata / rdata.
- Holds a word-organised memory with byte-lane writes and synchronous read.
- Supports an optional fixed wait-state count, reporting it through a busy output that the hazard unit folds into the fetch stall.
- Used as the fetch-side memory in simulation and FPGA builds; takes physical addresses after kseg0/kseg1 translation.

Parameters:
- ADDR_W, 14, word-address width; memory depth is 2^ADDR_W words.
- BASE_ADDR, 32'h1fc0_0000, physical base of the window; only bits [31:ADDR_W+2] are compared.
- WAIT_CYCLES, 0, extra busy cycles per accepted access (0..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- sram_en  in  1  access request.
- sram_wen  in  4  byte write enables; 0 means read.
- sram_addr  in  32  physical byte address.
- sram_wdata  in  32  write data.
- sram_rdata  out  32  read data, registered.
- sram_busy  out  1  responder cannot accept a request this cycle.
- addr_err  out  1  one-cycle pulse: completed access was out of window.
- rd_count  out  32  number of completed in-window reads, wraps.

Behaviour:
- Reset: clk and reset only; reset is synchronous, active-high.
  - Clears sram_rdata=0, sram_busy=0, addr_err=0, rd_count=0 and sets state IDLE.
  - Memory contents are not cleared.
  - Reset while in WAIT aborts the pending access: no write, no rdata update.
- Decode:
  - in_win = sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2].
  - idx = sram_addr[ADDR_W+1:2].
  - addr[1:0] is ignored; misalignment is the fetch stage's exception, not ours.
- Accept: sram_en && !sram_busy.
- WAIT_CYCLES=0, single cycle:
  - Accepted read: sram_rdata <= mem[idx] at the same edge, so data is visible the cycle after en.
  - Accepted write: for each lane i with wen[i]=1, mem[idx][8i+7:8i] <= wdata lane. sram_rdata holds its value.
  - sram_busy is constantly 0.
- WAIT_CYCLES=N>0, FSM IDLE / WAIT:
  - IDLE: on accept, latch addr/wen/wdata/in_win, cnt <= N, go to WAIT.
  - WAIT: sram_busy=1 (decoded from state). cnt decrements each edge. At the edge where cnt==1, perform the latched access exactly as in the N=0 case and return to IDLE.
  - Result: busy is high for N cycles, and rdata updates at the edge ending the last busy cycle.
  - sram_en during WAIT is ignored. The initiator must re-present the request once busy falls; the first cycle with busy=0 may accept a new request.
- Hold rule: sram_rdata changes only on completion of an in-window or out-of-window read. Idle cycles, writes and busy cycles keep the old value, because the fetch stage relies on rdata persisting while it stalls.
- Out of window:
  - Read completes with sram_rdata <= 32'h0 and addr_err=1 for exactly one cycle (the cycle the new rdata is visible).
  - Write is dropped, with addr_err=1 for one cycle.
  - rd_count is not incremented.
- rd_count increments by 1 on each completed in-window read and wraps from 32'hffff_ffff to 0.
- Same-address write then read on consecutive accepts returns the newly written data; there is no forwarding hazard because the accesses are sequential.

Test Plan:
- N=0, preload mem[4]=32'h1122_3344; en=1, wen=0, addr=32'h1fc0_0010 → next cycle rdata=32'h1122_3344, rd_count=1, addr_err=0.
- N=0, write wen=4'b0011, wdata=32'hAABB_CCDD to 32'h1fc0_0010, then read the same address → rdata=32'h1122_CCDD; rdata unchanged during the write cycle.
- N=0, read addr=32'h0000_0100 (out of window) → rdata=0, addr_err high exactly one cycle, rd_count unchanged. Then drop en for 3 cycles → rdata stays 0 (hold).
- N=3, read 32'h1fc0_0010 → busy high 3 cycles, en during busy ignored, rdata=32'h1122_CCDD visible in the first busy-low cycle. A back-to-back request in that cycle is accepted.
- N=3, write 32'hFFFF_FFFF with wen=4'hF to 32'h1fc0_0010, assert reset in the 2nd busy cycle, then read after reset → busy=0 and rdata=0 right after reset; the read returns 32'h1122_CCDD (write aborted).
- Force rd_count to 32'hffff_ffff via 2^32-1 reads (or a bench backdoor), then one in-window read → rd_count=0.
